// File: rtl/rstack_pkg.sv
// Shared definitions for the return stack: op encodings and modulo-DEPTH pointer helpers.
// Build option: define RSTACK_GUARD_EN to reject PUSH on a full stack instead of overwriting the oldest entry.
package rstack_pkg;

    localparam logic [1:0] RS_NONE = 2'b00;
    localparam logic [1:0] RS_PUSH = 2'b01;
    localparam logic [1:0] RS_POP  = 2'b10;
    localparam logic [1:0] RS_REPL = 2'b11;

`ifdef RSTACK_GUARD_EN
    localparam bit RS_GUARD = 1'b1;
`else
    localparam bit RS_GUARD = 1'b0;
`endif

    // Explicit compare against depth-1 so non-power-of-2 depths wrap correctly.
    function automatic int rs_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

    function automatic int rs_dec(input int p, input int depth);
        return (p == 0) ? depth - 1 : p - 1;
    endfunction

endpackage

// File: rtl/rstack_ptr.sv
// Top-pointer and occupancy tracking for the return stack; also decides which entry (if any) is written.
// Behaviour of PUSH on full depends on RSTACK_GUARD_EN (via rstack_pkg::RS_GUARD).
module rstack_ptr
    import rstack_pkg::*;
#(
    parameter int DEPTH = 5,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [1:0]    op,
    input  logic          clear,
    output logic [PW-1:0] ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          wr_en,
    output logic [PW-1:0] wr_idx,
    output logic          ovf,
    output logic          unf
);

    logic [PW-1:0] ptr_q, ptr_d, ptr_nxt, ptr_prv;
    logic [CW-1:0] count_q, count_d;
    logic          is_push;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign ptr_nxt = PW'(rs_inc(int'(ptr_q), DEPTH));
    assign ptr_prv = PW'(rs_dec(int'(ptr_q), DEPTH));
    // REPL on an empty stack is treated as a PUSH.
    assign is_push = op_valid && ((op == RS_PUSH) || ((op == RS_REPL) && empty));

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        ovf     = 1'b0;
        unf     = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (is_push) begin
            ovf = full;
            if (!(full && RS_GUARD)) begin
                ptr_d  = ptr_nxt;
                wr_en  = 1'b1;
                wr_idx = ptr_nxt;
                if (!full) count_d = count_q + CW'(1);
            end
        end else if (op_valid && (op == RS_POP)) begin
            if (empty) begin
                unf = 1'b1;
            end else begin
                ptr_d   = ptr_prv;
                count_d = count_q - CW'(1);
            end
        end else if (op_valid && (op == RS_REPL)) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign ptr   = ptr_q;
    assign count = count_q;

endmodule

// File: rtl/rstack_ctrl.sv
// Parametrised circular-buffer return stack: storage, registered error events and sticky flags.
// Define RSTACK_GUARD_EN to reject PUSH on full (default: overwrite oldest entry).
module rstack_ctrl
    import rstack_pkg::*;
#(
    parameter int AW    = 10,
    parameter int DEPTH = 5,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    input  logic [1:0]    op,
    input  logic [AW-1:0] push_data,
    input  logic          clear,
    input  logic          err_clr,
    output logic [AW-1:0] top_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          ovf_evt,
    output logic          unf_evt,
    output logic          ovf_flag,
    output logic          unf_flag
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [AW-1:0] mem_d [DEPTH];
    logic [PW-1:0] ptr, wr_idx;
    logic          wr_en, ovf, unf;
    logic          ovf_evt_q, ovf_evt_d, unf_evt_q, unf_evt_d;
    logic          ovf_flag_q, ovf_flag_d, unf_flag_q, unf_flag_d;

    rstack_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .clear    (clear),
        .ptr      (ptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .ovf      (ovf),
        .unf      (unf)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_idx] = push_data;
        ovf_evt_d = ovf;
        unf_evt_d = unf;
        // A same-cycle error event beats err_clr.
        ovf_flag_d = ovf | (ovf_flag_q & ~err_clr);
        unf_flag_d = unf | (unf_flag_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ovf_evt_q  <= 1'b0;
            unf_evt_q  <= 1'b0;
            ovf_flag_q <= 1'b0;
            unf_flag_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            ovf_evt_q  <= ovf_evt_d;
            unf_evt_q  <= unf_evt_d;
            ovf_flag_q <= ovf_flag_d;
            unf_flag_q <= unf_flag_d;
        end
    end

    assign top_data = mem_q[ptr];
    assign ovf_evt  = ovf_evt_q;
    assign unf_evt  = unf_evt_q;
    assign ovf_flag = ovf_flag_q;
    assign unf_flag = unf_flag_q;

endmodule

// File: tb/tb_rstack_ctrl.sv
// Self-checking bench for rstack_ctrl (AW=10, DEPTH=5); expected tops are queued and popped against the DUT.
module tb_rstack_ctrl;

    logic       clk = 1'b0;
    logic       rst, op_valid, clear, err_clr;
    logic [1:0] op;
    logic [9:0] push_data, top_data;
    logic [2:0] count;
    logic       empty, full, ovf_evt, unf_evt, ovf_flag, unf_flag;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    rstack_ctrl #(.AW(10), .DEPTH(5)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .push_data(push_data),
        .clear(clear), .err_clr(err_clr), .top_data(top_data), .count(count),
        .empty(empty), .full(full), .ovf_evt(ovf_evt), .unf_evt(unf_evt),
        .ovf_flag(ovf_flag), .unf_flag(unf_flag)
    );

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [1:0] o, input logic [9:0] d,
                        input logic c, input logic ec);
        op_valid = v; op = o; push_data = d; clear = c; err_clr = ec;
        @(posedge clk); #1;
        op_valid = 1'b0; op = 2'b00; clear = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (top_data !== 10'h000) begin errors++; $display("FAIL reset_top got %h exp 000", top_data); end
        checks++; if ({empty, full, ovf_evt, unf_evt, ovf_flag, unf_flag} !== 6'b100000) begin
            errors++; $display("FAIL reset_status got %b exp 100000", {empty, full, ovf_evt, unf_evt, ovf_flag, unf_flag}); end
    endtask

    task automatic test_lifo();
        do_reset();
        step(1, 2'b01, 10'h101, 0, 0); exp_q.push_front(10'h101);
        step(1, 2'b01, 10'h202, 0, 0); exp_q.push_front(10'h202);
        step(1, 2'b01, 10'h303, 0, 0); exp_q.push_front(10'h303);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL lifo_count got %0d exp 3", count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (top_data !== e) begin errors++; $display("FAIL lifo_pop got %h exp %h", top_data, e); end
            step(1, 2'b10, 10'h000, 0, 0);
        end
        checks++; if (empty !== 1'b1 || count !== 3'd0) begin
            errors++; $display("FAIL lifo_empty got empty=%b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1, 2'b01, 10'(i), 0, 0);
            checks++; if (ovf_evt !== (i == 6)) begin
                errors++; $display("FAIL ovf_evt_push%0d got %b exp %b", i, ovf_evt, (i == 6)); end
        end
`ifdef RSTACK_GUARD_EN
        for (int i = 5; i >= 1; i--) exp_q.push_back(10'(i));
`else
        for (int i = 6; i >= 2; i--) exp_q.push_back(10'(i));
`endif
        checks++; if (ovf_flag !== 1'b1 || count !== 3'd5 || full !== 1'b1) begin
            errors++; $display("FAIL ovf_state got flag=%b count=%0d full=%b exp 1/5/1", ovf_flag, count, full); end
        step(0, 2'b00, 10'h000, 0, 0);
        checks++; if (ovf_evt !== 1'b0 || ovf_flag !== 1'b1) begin
            errors++; $display("FAIL ovf_pulse_len got evt=%b flag=%b exp 0/1", ovf_evt, ovf_flag); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (top_data !== e) begin errors++; $display("FAIL ovf_pop got %h exp %h", top_data, e); end
            step(1, 2'b10, 10'h000, 0, 0);
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ovf_drain got %0d exp 0", count); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1, 2'b10, 10'h000, 0, 0);
        checks++; if (unf_evt !== 1'b1 || unf_flag !== 1'b1) begin
            errors++; $display("FAIL unf_evt got evt=%b flag=%b exp 1/1", unf_evt, unf_flag); end
        checks++; if (top_data !== 10'h000 || count !== 3'd0) begin
            errors++; $display("FAIL unf_state got top=%h count=%0d exp 000/0", top_data, count); end
        step(0, 2'b00, 10'h000, 0, 0);
        checks++; if (unf_evt !== 1'b0 || unf_flag !== 1'b1) begin
            errors++; $display("FAIL unf_pulse_len got evt=%b flag=%b exp 0/1", unf_evt, unf_flag); end
        step(0, 2'b00, 10'h000, 0, 1);
        checks++; if (unf_flag !== 1'b0) begin errors++; $display("FAIL unf_errclr got %b exp 0", unf_flag); end
    endtask

    task automatic test_repl();
        do_reset();
        step(1, 2'b01, 10'h0AA, 0, 0);
        step(1, 2'b11, 10'h155, 0, 0);
        checks++; if (top_data !== 10'h155 || count !== 3'd1) begin
            errors++; $display("FAIL repl_top got top=%h count=%0d exp 155/1", top_data, count); end
        do_reset();
        step(1, 2'b11, 10'h077, 0, 0);
        checks++; if (top_data !== 10'h077 || count !== 3'd1) begin
            errors++; $display("FAIL repl_empty got top=%h count=%0d exp 077/1", top_data, count); end
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 2'b01, 10'(i + 8), 0, 0);
        step(1, 2'b01, 10'h3FF, 1, 0);
        checks++; if (count !== 3'd0 || empty !== 1'b1 || ovf_evt !== 1'b0) begin
            errors++; $display("FAIL clear got count=%0d empty=%b ovf=%b exp 0/1/0", count, empty, ovf_evt); end
        step(1, 2'b01, 10'h011, 0, 0);
        checks++; if (top_data !== 10'h011 || count !== 3'd1) begin
            errors++; $display("FAIL clear_push got top=%h count=%0d exp 011/1", top_data, count); end
    endtask

    task automatic test_err_race();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 2'b01, 10'(i + 1), 0, 0);
        step(1, 2'b01, 10'h123, 0, 1);
        checks++; if (ovf_flag !== 1'b1 || ovf_evt !== 1'b1) begin
            errors++; $display("FAIL race_flag got flag=%b evt=%b exp 1/1", ovf_flag, ovf_evt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 2'b01, 10'(i + 1), 0, 0);
        step(1, 2'b10, 10'h000, 0, 0);
        step(1, 2'b10, 10'h000, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 2'b10, 10'h000, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 2'b01, 10'(i + 1), 0, 0);
        rst = 1'b1;
        step(1, 2'b01, 10'h3AB, 0, 0);
        rst = 1'b0;
        checks++; if (count !== 3'd0 || top_data !== 10'h000) begin
            errors++; $display("FAIL rst_mid got count=%0d top=%h exp 0/000", count, top_data); end
        checks++; if ({ovf_evt, unf_evt, ovf_flag, unf_flag} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_flags got %b exp 0000", {ovf_evt, unf_evt, ovf_flag, unf_flag}); end
    endtask

    initial begin
        rst = 1'b0; op_valid = 1'b0; op = 2'b00; push_data = '0; clear = 1'b0; err_clr = 1'b0;
        #2;
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_repl();
        test_clear();
        test_err_race();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
